bin2gray: RTL and testbench
===========================

# bin2gray

Binary-to-Gray code converter, parameterised in width, used wherever a counter value must cross a clock domain or drive a position encoder with single-bit transitions. It has a zero-latency combinational output for direct use. It also has a one-cycle registered output with a valid flag and a Gray-to-binary round-trip self-check. The block sits between a binary counter and a synchroniser or output pin.

## Interface
- WIDTH, 4, bit width of binary input and Gray output (≥ 2).
- clk  input  1  single clock; all registers sample on rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registers immediately.
- a  input  WIDTH  binary value to convert.
- in_valid  input  1  qualifies `a` for the registered path.
- b  output  WIDTH  combinational Gray code of `a`, no clock involvement.
- b_q  output  WIDTH  registered Gray code of `a` captured when `in_valid` = 1.
- out_valid  output  1  high for one cycle after each accepted `in_valid`.
- step_err  output  1  registered; set when two consecutive accepted Gray codes differ in other than exactly one bit while the binary inputs differ by ±1 (mod 2^WIDTH).
- rt_err  output  1  registered; set when the Gray-to-binary inverse of `b_q` does not equal the captured binary value (self-check, never expected high).

## Operation
- Conversion: b[WIDTH-1] = a[WIDTH-1]; b[i] = a[i+1] XOR a[i] for i < WIDTH-1, i.e. b = a ^ (a >> 1).
- `b` is purely combinational and is valid whenever `a` is stable, including during reset.
- On a rising clk edge with in_valid = 1:
  - b_q ← b and a_last ← a.
  - out_valid ← 1.
- On a rising clk edge with in_valid = 0:
  - out_valid ← 0.
  - b_q, a_last and the error flags hold their values.
- step_err: on an accepted sample where a previous accepted sample exists, step_err ← 1 if (a − a_last) mod 2^WIDTH ∈ {1, 2^WIDTH−1} and popcount(b ^ b_q) ≠ 1.
- step_err is sticky until reset.
- rt_err: the inverse conversion is g2b[WIDTH-1] = g[WIDTH-1]; g2b[i] = g2b[i+1] XOR g[i]. On each accepted sample, rt_err ← rt_err | (g2b(b) ≠ a). rt_err is sticky.
- Wrap-around: all-ones → zero is a legal single-bit step (for WIDTH = 4, 1000 → 0000).
- Non-adjacent inputs (e.g. 0 → 5) never set step_err.
- Reset values: b_q = 0, out_valid = 0, step_err = 0, rt_err = 0, the internal "have previous sample" flag = 0.
- Reset mid-operation clears the registered path at once. The first sample after reset is never compared for step_err.

## Timing
- `b`: zero-cycle latency, combinational delay only (an XOR level).
- `b_q`, `out_valid`: one-cycle latency from the accepting edge.
- `step_err`, `rt_err`: valid in the same cycle as the corresponding `out_valid`.
- Back-to-back in_valid every cycle is supported; throughput is one conversion per clock.
- No backpressure.
- Asynchronous reset assertion takes effect without a clock edge. Deassertion is expected synchronous to clk, and the first accept can occur on the first edge after deassertion.

## Structure
- A shared package holds the functions bin2gray_f(x) and gray2bin_f(g), both width-generic, plus the function popcount_f.
- Natural sub-module: gray2bin (combinational inverse), instantiated for the rt_err check and reusable by consumers on the far side of a CDC.
- Top level: combinational converter, capture register, step/round-trip checkers.

## Test plan
- Exhaustive combinational sweep, WIDTH = 4, `b` checked 5 time units after each change:
  - 0000→0000, 0001→0001, 0010→0011, 0011→0010.
  - 0100→0110, 0101→0111, 0110→0101, 0111→0100.
  - 1000→1100, 1001→1101, 1010→1111, 1011→1110.
  - 1100→1010, 1101→1011, 1110→1001, 1111→1000.
- Registered path: in_valid pulse with a = 1010 → next edge b_q = 1111, out_valid = 1 for exactly one cycle, rt_err = 0.
- Counting stream 0..15 then 0 with in_valid held high → every consecutive b_q differs in one bit, step_err stays 0 across the 1111→0000 wrap.
- Non-adjacent jump 0011 → 1100 → step_err remains 0. Forced-fault hook (checker fed corrupted Gray 0000 after 0010) → step_err = 1 and stays set.
- Assert rst mid-stream (a = 0110 accepted) → b_q = 0, out_valid = 0, step_err = 0, rt_err = 0 immediately. `b` still equals 0101 during reset.
- WIDTH = 8 instance: a = 8'hFF → b = 8'h80; a = 8'h80 → b = 8'hC0.

Source files
------------

// File: rtl/bin2gray_pkg.sv
// Shared Gray-code helpers: width-generic conversion functions and a popcount,
// operating on MAX_W-bit zero-extended values so any WIDTH up to MAX_W can use them.
package bin2gray_pkg;

  localparam int unsigned MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t bin2gray_f(input word_t x);
    return x ^ (x >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unchanged, so any WIDTH <= MAX_W works.
  function automatic word_t gray2bin_f(input word_t g);
    word_t r;
    r[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  function automatic int unsigned popcount_f(input word_t x);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += 32'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2gray_g2b.sv
// Combinational Gray-to-binary inverse; also usable on the far side of a CDC.
module gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down; each bit depends on the one above it.
  always_comb begin
    bin[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ g[i];
    end
  end

endmodule

// File: rtl/bin2gray.sv
// Binary-to-Gray converter with a zero-latency output, a registered output with
// valid flag, a single-bit-step checker and a Gray-to-binary round-trip self-check.
module bin2gray
  import bin2gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_q,
  output logic             out_valid,
  output logic             step_err,
  output logic             rt_err
);

  logic [WIDTH-1:0] a_last;
  logic             have_prev;
  logic [WIDTH-1:0] chk_gray;
  logic [WIDTH-1:0] rt_bin;
  logic [WIDTH-1:0] a_diff;
  logic             adjacent;
  logic             step_bad;

  assign b = WIDTH'(bin2gray_f(MAX_W'(a)));

  // The step checker looks at its own copy of the Gray code so a corrupted value
  // can be injected there without disturbing b or b_q.
  assign chk_gray = b;

  gray2bin #(.WIDTH(WIDTH)) u_g2b (
    .g   (b),
    .bin (rt_bin)
  );

  assign a_diff   = a - a_last;
  assign adjacent = (a_diff == WIDTH'(1)) || (a_diff == {WIDTH{1'b1}});
  assign step_bad = have_prev && adjacent &&
                    (popcount_f(MAX_W'(chk_gray ^ b_q)) != 1);

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values (step_bad compares against the old b_q/a_last, not the new ones).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q       <= '0;
      a_last    <= '0;
      have_prev <= 1'b0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      rt_err    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        b_q       <= b;
        a_last    <= a;
        have_prev <= 1'b1;
        step_err  <= step_err | step_bad;
        rt_err    <= rt_err | (rt_bin != a);
      end
    end
  end

endmodule

// File: tb/tb_bin2gray.sv
// Scoreboard bench for bin2gray: directed stimulus pushes expected registered
// responses, a negedge monitor pops and compares whenever out_valid is high.
module tb_bin2gray;

  typedef struct {
    logic [3:0] gray;
    logic       step;
    logic       rt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic       in_valid = 1'b0;
  logic [3:0] b, b_q;
  logic       out_valid, step_err, rt_err;

  logic [7:0] a8 = '0;
  logic       in_valid8 = 1'b0;
  logic [7:0] b8, b_q8;
  logic       out_valid8, step_err8, rt_err8;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  bin2gray #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .in_valid(in_valid),
    .b(b), .b_q(b_q), .out_valid(out_valid), .step_err(step_err), .rt_err(rt_err)
  );

  bin2gray #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .in_valid(in_valid8),
    .b(b8), .b_q(b_q8), .out_valid(out_valid8), .step_err(step_err8), .rt_err(rt_err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [3:0] av, input logic [3:0] gv, input logic sv);
    exp_t e;
    @(posedge clk);
    #1;
    a = av;
    in_valid = 1'b1;
    e.gray = gv;
    e.step = sv;
    e.rt = 1'b0;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_b_q", 32'(b_q), 32'(e.gray));
          check("sb_step_err", 32'(step_err), 32'(e.step));
          check("sb_rt_err", 32'(rt_err), 32'(e.rt));
        end
      end
    end
  end

  initial begin : stim
    #12;
    check("reset_b_q", 32'(b_q), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_step_err", 32'(step_err), 32'd0);
    check("reset_rt_err", 32'(rt_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      #5;
      check($sformatf("comb_b_%0d", i), 32'(b), 32'(gray_tab[i]));
    end

    accept(4'b1010, 4'b1111, 1'b0);
    idle();
    @(negedge clk);
    check("pulse_b_q", 32'(b_q), 32'b1111);
    check("pulse_out_valid_hi", 32'(out_valid), 32'd1);
    check("pulse_rt_err", 32'(rt_err), 32'd0);
    @(negedge clk);
    check("pulse_out_valid_lo", 32'(out_valid), 32'd0);

    for (int i = 0; i < 16; i++) begin
      accept(4'(i), gray_tab[i], 1'b0);
    end
    accept(4'b0000, 4'b0000, 1'b0);

    accept(4'b0011, 4'b0010, 1'b0);
    accept(4'b1100, 4'b1010, 1'b0);

    accept(4'b0010, 4'b0011, 1'b0);
    accept(4'b0011, 4'b0010, 1'b1);
    force dut.chk_gray = 4'b0000;
    idle();
    release dut.chk_gray;
    accept(4'b0100, 4'b0110, 1'b1);
    accept(4'b0110, 4'b0101, 1'b1);
    idle();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_b_q", 32'(b_q), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_step_err", 32'(step_err), 32'd0);
    check("midrst_rt_err", 32'(rt_err), 32'd0);
    check("midrst_b", 32'(b), 32'b0101);
    @(posedge clk);
    #1;
    rst = 1'b0;

    accept(4'b0001, 4'b0001, 1'b0);
    accept(4'b0000, 4'b0000, 1'b0);
    idle();

    a8 = 8'hFF;
    #5;
    check("w8_ff", 32'(b8), 32'h80);
    a8 = 8'h80;
    #5;
    check("w8_80", 32'(b8), 32'hC0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
